muldiv_unit: RTL and testbench

Iterative multiply/divide unit with HI/LO registers for the extended-instruction MIPS core, sitting beside the ALU and its ALU control decoder in the EX stage. It decodes R-type funct codes for mult/multu/div/divu/mfhi/mflo/mthi/mtlo directly, runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles, and reports progress with a start/busy/done handshake. The core stalls on busy.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_unit_if.sv | 25 ++
 rtl/muldiv_unit_cond_neg.sv | 11 +
 rtl/muldiv_unit.sv | 159 +++++++++++++++
 tb/tb_muldiv_unit.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: R-type funct codes,
// controller states and a decode helper.
package muldiv_pkg;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_e;

    // True for the four funct codes that occupy the iterative datapath.
    function automatic logic is_long_op(input logic [5:0] funct);
        return (funct == F_MULT) || (funct == F_MULTU) ||
               (funct == F_DIV)  || (funct == F_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the EX-stage core (master) and the
// multiply/divide unit (slave).
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] rdata;

    modport master (
        output start, funct, a, b,
        input  busy, done, hi, lo, rdata
    );

    modport slave (
        input  start, funct, a, b,
        output busy, done, hi, lo, rdata
    );
endinterface

// File: rtl/muldiv_unit_cond_neg.sv
// Conditional two's-complement negate, used both to take operand magnitudes and
// to restore result signs.
module cond_neg #(
    parameter int WIDTH = 32
) (
    input  logic             neg_i,
    input  logic [WIDTH-1:0] a_i,
    output logic [WIDTH-1:0] y_o
);
    assign y_o = neg_i ? (~a_i + 1'b1) : a_i;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide with HI/LO registers. Signed
// operations run on magnitudes and fix the signs in a final FIX cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    localparam int             CW        = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);

    state_e               state_q;
    logic [CW-1:0]        count_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     opnd_q;
    logic                 is_div_q;
    logic                 res_neg_q;
    logic                 rem_neg_q;
    logic                 div0_q;
    logic                 busy_q;
    logic                 done_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;

    // Issue-side decode and operand magnitudes.
    logic             is_signed;
    logic             is_div_op;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign is_signed = (bus.funct == F_MULT) || (bus.funct == F_DIV);
    assign is_div_op = (bus.funct == F_DIV)  || (bus.funct == F_DIVU);
    assign sign_a    = is_signed & bus.a[WIDTH-1];
    assign sign_b    = is_signed & bus.b[WIDTH-1];

    cond_neg #(.WIDTH(WIDTH)) u_mag_a (.neg_i(sign_a), .a_i(bus.a), .y_o(mag_a));
    cond_neg #(.WIDTH(WIDTH)) u_mag_b (.neg_i(sign_b), .a_i(bus.b), .y_o(mag_b));

    // Multiply step: acc = {partial product, remaining multiplier bits}.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                               : {1'b0, acc_q[2*WIDTH-1:1]};

    // Divide step: acc = {partial remainder, dividend/quotient bits}. The shifted
    // remainder needs one extra bit before the trial subtract.
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_fits;
    logic [2*WIDTH-1:0] div_next;

    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_fits  = div_shift >= {1'b0, opnd_q};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_next  = {div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0],
                        acc_q[WIDTH-2:0], div_fits};

    // Result sign fix-up; a most-negative overflow quotient wraps back to itself.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    cond_neg #(.WIDTH(2*WIDTH)) u_fix_prod (
        .neg_i(res_neg_q), .a_i(acc_q), .y_o(prod_fix)
    );
    cond_neg #(.WIDTH(WIDTH)) u_fix_quo (
        .neg_i(res_neg_q), .a_i(acc_q[WIDTH-1:0]), .y_o(quo_fix)
    );
    cond_neg #(.WIDTH(WIDTH)) u_fix_rem (
        .neg_i(rem_neg_q), .a_i(acc_q[2*WIDTH-1:WIDTH]), .y_o(rem_fix)
    );

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (is_long_op(bus.funct)) begin
                            state_q   <= RUN;
                            busy_q    <= 1'b1;
                            count_q   <= '0;
                            acc_q     <= {{WIDTH{1'b0}}, mag_a};
                            opnd_q    <= mag_b;
                            is_div_q  <= is_div_op;
                            res_neg_q <= sign_a ^ sign_b;
                            rem_neg_q <= sign_a;
                            div0_q    <= (bus.b == '0);
                        end else if (bus.funct == F_MTHI) begin
                            hi_q <= bus.a;
                        end else if (bus.funct == F_MTLO) begin
                            lo_q <= bus.a;
                        end
                    end
                end
                RUN: begin
                    acc_q   <= is_div_q ? div_next : mul_next;
                    count_q <= count_q + 1'b1;
                    if (count_q == LAST_STEP) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (is_div_q) begin
                        lo_q <= div0_q ? {WIDTH{1'b1}} : quo_fix;
                        hi_q <= rem_fix;
                    end else begin
                        {hi_q, lo_q} <= prod_fix;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    count_q <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: every branch assigns rdata, so this read mux cannot infer a latch.
    logic [WIDTH-1:0] rdata;
    always_comb begin
        rdata = '0;
        if (bus.funct == F_MFHI) begin
            rdata = hi_q;
        end else if (bus.funct == F_MFLO) begin
            rdata = lo_q;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.rdata = rdata;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32: results, handshake timing,
// ignored issues, HI/LO moves and mid-operation reset.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; start is held across exactly one rising edge.
    task automatic drive_start(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.funct = f;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.funct = 6'b000000;
    endtask

    // Counts falling edges until done; notes any cycle where busy was low.
    task automatic wait_done(input int budget, output int cycles, output logic busy_gap);
        cycles   = 0;
        busy_gap = 1'b0;
        while (bus.done !== 1'b1 && cycles < budget) begin
            if (bus.busy !== 1'b1) busy_gap = 1'b1;
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic run_op(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo);
        int   n;
        logic gap;
        drive_start(f, a, b);
        check({tag, "_busy_on"}, 64'(bus.busy), 64'd1);
        check({tag, "_done_clear"}, 64'(bus.done), 64'd0);
        wait_done(100, n, gap);
        check({tag, "_latency"}, 64'(n), 64'd33);
        check({tag, "_busy_held"}, 64'(gap), 64'd0);
        check({tag, "_busy_off"}, 64'(bus.busy), 64'd0);
        check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    endtask

    initial begin
        int   n;
        int   pulses;
        logic gap;

        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.funct = 6'b000000;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back: each run_op issues in the cycle the previous done is high.
        run_op("mult",  F_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("multu", F_MULTU, 32'hFFFFFFFD, 32'd5,        32'h00000004, 32'hFFFFFFF1);
        run_op("divu",  F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14);
        run_op("div",   F_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div0",  F_DIV,   32'd1234,     32'd0,        32'h000004D2, 32'hFFFFFFFF);
        run_op("divu0", F_DIVU,  32'hFFFFFF00, 32'd0,        32'hFFFFFF00, 32'hFFFFFFFF);
        run_op("ovf",   F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run_op("divn",  F_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        @(negedge clk);
        check("done_pulse_end", 64'(bus.done), 64'd0);

        // divu issued mid-RUN must be ignored.
        drive_start(F_MULT, 32'hFFFFFFFD, 32'd5);
        repeat (10) @(negedge clk);
        drive_start(F_DIVU, 32'd100, 32'd7);
        wait_done(100, n, gap);
        check("ign_latency", 64'(n + 11), 64'd33);
        check("ign_busy_held", 64'(gap), 64'd0);
        check("ign_hi", 64'(bus.hi), 64'hFFFFFFFF);
        check("ign_lo", 64'(bus.lo), 64'hFFFFFFF1);
        @(negedge clk);

        // HI/LO moves and the read mux.
        drive_start(F_MTHI, 32'hDEADBEEF, 32'd0);
        check("mthi_busy", 64'(bus.busy), 64'd0);
        check("mthi_done", 64'(bus.done), 64'd0);
        bus.funct = F_MFHI;
        #1 check("mfhi_rdata", 64'(bus.rdata), 64'hDEADBEEF);
        bus.funct = F_MFLO;
        #1 check("mflo_rdata", 64'(bus.rdata), 64'hFFFFFFF1);
        bus.funct = F_ADD_OTHER();
        #1 check("other_rdata", 64'(bus.rdata), 64'd0);
        bus.funct = 6'b000000;
        @(negedge clk);

        // mtlo while busy is dropped.
        drive_start(F_MULTU, 32'd2, 32'd3);
        repeat (5) @(negedge clk);
        drive_start(F_MTLO, 32'h12345678, 32'd0);
        check("mtlo_busy_lo", 64'(bus.lo), 64'hFFFFFFF1);
        wait_done(100, n, gap);
        check("mtlo_busy_latency", 64'(n + 6), 64'd33);
        check("mtlo_busy_hi", 64'(bus.hi), 64'd0);
        check("mtlo_busy_lo_res", 64'(bus.lo), 64'd6);
        @(negedge clk);

        // Reset mid-RUN aborts with no later done.
        drive_start(F_MULT, 32'd7, 32'd9);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_hi", 64'(bus.hi), 64'd0);
        check("abort_lo", 64'(bus.lo), 64'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
        end
        check("abort_quiet", 64'(pulses), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // A funct outside the mf* pair (add) for the read-mux default.
    function automatic logic [5:0] F_ADD_OTHER();
        return 6'b100000;
    endfunction

endmodule
